// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode stage. It sits directly upstream of the register
// file. Fetched instructions arrive over a valid/ready handshake. The stage
// decodes their fields into a one-deep output register for the execute stage,
// and drives the register-file read port in step with that register.
//
// A pending-write scoreboard holds one bit per architectural register.
// - A bit is set when an instruction that writes that register is accepted.
// - A bit is cleared when writeback reports the register.
// An incoming instruction whose source register is still pending stalls
// until writeback clears it.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active low
//   i_instr_valid  upstream instruction valid
//   o_instr_ready  stage can accept an instruction this cycle
//   i_instr        instruction word
//   i_pc_in        instruction PC
//   o_rs1_add      register-file read address 1 (0 when rs1 unused)
//   o_rs2_add      register-file read address 2 (0 when rs2 unused)
//   o_rd_en        register-file read enable, aligned with o_dec_valid
//   o_dec_valid    decoded instruction valid
//   i_dec_ready    execute stage accepts the decoded instruction
//   o_dec_opcode   instr[6:0]
//   o_dec_funct3   instr[14:12]
//   o_dec_funct7   instr[31:25]
//   o_dec_rd       instr[11:7]
//   o_dec_wd_en    instruction writes a non-zero rd
//   o_dec_imm      sign-extended immediate (0 for R-type and illegal)
//   o_dec_pc       registered instruction PC
//   o_illegal      unsupported opcode
//   i_wb_en        a register is written back this cycle
//   i_wb_sel       register being written back
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [XLEN-1:0]       i_instr,
  input  logic [XLEN-1:0]       i_pc_in,
  output logic [REG_ADDR_W-1:0] o_rs1_add,
  output logic [REG_ADDR_W-1:0] o_rs2_add,
  output logic                  o_rd_en,
  output logic                  o_dec_valid,
  input  logic                  i_dec_ready,
  output logic [6:0]            o_dec_opcode,
  output logic [2:0]            o_dec_funct3,
  output logic [6:0]            o_dec_funct7,
  output logic [REG_ADDR_W-1:0] o_dec_rd,
  output logic                  o_dec_wd_en,
  output logic [XLEN-1:0]       o_dec_imm,
  output logic [XLEN-1:0]       o_dec_pc,
  output logic                  o_illegal,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_sel
);

  localparam int NREGS = 1 << REG_ADDR_W;

  localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1Addr;
  logic [REG_ADDR_W-1:0] w_rs2Addr;

  logic                  w_supported;
  logic                  w_useRs1;
  logic                  w_useRs2;
  logic                  w_writesRd;
  logic                  w_wdEn;
  logic [31:0]           w_imm32;
  logic [XLEN-1:0]       w_imm;

  logic [NREGS-1:0]      w_clearMask;
  logic [NREGS-1:0]      w_setMask;
  logic [NREGS-1:0]      w_pendVisible;
  logic                  w_hazard;
  logic                  w_accept;

  logic [NREGS-1:0]      r_pending;
  logic                  r_decValid;
  logic                  r_rdEn;
  logic [REG_ADDR_W-1:0] r_rs1Add;
  logic [REG_ADDR_W-1:0] r_rs2Add;
  logic [6:0]            r_opcode;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_wdEn;
  logic [XLEN-1:0]       r_imm;
  logic [XLEN-1:0]       r_pc;
  logic                  r_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_rd     = REG_ADDR_W'(i_instr[11:7]);
  assign w_rs1    = REG_ADDR_W'(i_instr[19:15]);
  assign w_rs2    = REG_ADDR_W'(i_instr[24:20]);

  // Classify the incoming opcode.
  // This yields which source registers it reads, whether it may write rd,
  // and which immediate format applies. Unsupported opcodes fall to the
  // default: they read nothing, write nothing and carry a zero immediate,
  // so they pass through the stage without touching the scoreboard.
  always_comb begin
    w_supported = 1'b1;
    w_useRs1    = 1'b0;
    w_useRs2    = 1'b0;
    w_writesRd  = 1'b1;
    w_imm32     = '0;
    case (w_opcode)
      OP_R: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_useRs1 = 1'b1;
        w_imm32  = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        w_useRs1   = 1'b1;
        w_useRs2   = 1'b1;
        w_writesRd = 1'b0;
        w_imm32    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        w_useRs1   = 1'b1;
        w_useRs2   = 1'b1;
        w_writesRd = 1'b0;
        w_imm32    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      default: begin
        w_supported = 1'b0;
        w_writesRd  = 1'b0;
      end
    endcase
  end

  assign w_wdEn    = w_writesRd && (w_rd != '0);
  assign w_imm     = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
  assign w_rs1Addr = w_useRs1 ? w_rs1 : '0;
  assign w_rs2Addr = w_useRs2 ? w_rs2 : '0;

  // Build the one-hot writeback clear mask.
  // Writeback to x0 is meaningless, so it produces no mask at all.
  always_comb begin
    w_clearMask = '0;
    if (i_wb_en && (i_wb_sel != '0)) begin
      w_clearMask[i_wb_sel] = 1'b1;
    end
  end

  // The hazard check looks at the scoreboard as it will be after this
  // cycle's writeback. A register written back this cycle can therefore be
  // read immediately, because the register file writes through.
  assign w_pendVisible = r_pending & ~w_clearMask;
  assign w_hazard      = (w_useRs1 && w_pendVisible[w_rs1]) ||
                         (w_useRs2 && w_pendVisible[w_rs2]);

  assign o_instr_ready = (!r_decValid || i_dec_ready) && !w_hazard;
  assign w_accept      = i_instr_valid && o_instr_ready;

  // Build the one-hot set mask for the destination of an accepted writer.
  // w_wdEn already excludes x0.
  always_comb begin
    w_setMask = '0;
    if (w_accept && w_wdEn) begin
      w_setMask[w_rd] = 1'b1;
    end
  end

  // Pending-write scoreboard.
  // Clears are applied before sets, so a set and a clear of the same
  // register in one cycle leave the bit set; the newly accepted writer is
  // the younger one. Bit 0 is masked so x0 can never stall anything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clearMask) | w_setMask) & X0_MASK;
    end
  end

  // One-deep decode output register.
  // An accept loads every field and raises valid and the read enable
  // together, so the register-file addresses line up with o_dec_valid.
  // When the execute stage takes the entry and nothing new arrives, only
  // valid and the read enable drop. While execute back-pressures, the
  // whole register holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_decValid <= 1'b0;
      r_rdEn     <= 1'b0;
      r_rs1Add   <= '0;
      r_rs2Add   <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rd       <= '0;
      r_wdEn     <= 1'b0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_decValid <= 1'b1;
      r_rdEn     <= 1'b1;
      r_rs1Add   <= w_rs1Addr;
      r_rs2Add   <= w_rs2Addr;
      r_opcode   <= w_opcode;
      r_funct3   <= w_funct3;
      r_funct7   <= w_funct7;
      r_rd       <= w_rd;
      r_wdEn     <= w_wdEn;
      r_imm      <= w_imm;
      r_pc       <= i_pc_in;
      r_illegal  <= !w_supported;
    end else if (i_dec_ready) begin
      r_decValid <= 1'b0;
      r_rdEn     <= 1'b0;
    end
  end

  assign o_dec_valid  = r_decValid;
  assign o_rd_en      = r_rdEn;
  assign o_rs1_add    = r_rs1Add;
  assign o_rs2_add    = r_rs2Add;
  assign o_dec_opcode = r_opcode;
  assign o_dec_funct3 = r_funct3;
  assign o_dec_funct7 = r_funct7;
  assign o_dec_rd     = r_rd;
  assign o_dec_wd_en  = r_wdEn;
  assign o_dec_imm    = r_imm;
  assign o_dec_pc     = r_pc;
  assign o_illegal    = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. It has three parts:
// - A table of hand-decoded instructions, each applied from reset.
// - Hand-written sequences for the stall, back-pressure, x0, illegal-opcode
//   and reset-mid-stall scenarios.
// - A randomized run checked against a behavioural model. The model keeps
//   a pending-register array and decodes from the RV32I field rules.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk;
  logic        rstN;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] pcIn;
  logic [4:0]  rs1Add;
  logic [4:0]  rs2Add;
  logic        rdEn;
  logic        decValid;
  logic        decReady;
  logic [6:0]  decOpcode;
  logic [2:0]  decFunct3;
  logic [6:0]  decFunct7;
  logic [4:0]  decRd;
  logic        decWdEn;
  logic [31:0] decImm;
  logic [31:0] decPc;
  logic        illegal;
  logic        wbEn;
  logic [4:0]  wbSel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wdEn;
    logic        ill;
  } vecT;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wd;
    logic        ill;
  } decT;

  vecT  vecs [12];
  bit   mPend [32];
  bit   mValid;
  decT  mDec;
  logic [31:0] mWord;
  logic [31:0] mPc;

  decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_instr_valid (instrValid),
    .o_instr_ready (instrReady),
    .i_instr       (instr),
    .i_pc_in       (pcIn),
    .o_rs1_add     (rs1Add),
    .o_rs2_add     (rs2Add),
    .o_rd_en       (rdEn),
    .o_dec_valid   (decValid),
    .i_dec_ready   (decReady),
    .o_dec_opcode  (decOpcode),
    .o_dec_funct3  (decFunct3),
    .o_dec_funct7  (decFunct7),
    .o_dec_rd      (decRd),
    .o_dec_wd_en   (decWdEn),
    .o_dec_imm     (decImm),
    .o_dec_pc      (decPc),
    .o_illegal     (illegal),
    .i_wb_en       (wbEn),
    .i_wb_sel      (wbSel)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w,
                               input logic [31:0] pc, input logic dr,
                               input logic we, input logic [4:0] ws);
    instrValid = v;
    instr      = w;
    pcIn       = pc;
    decReady   = dr;
    wbEn       = we;
    wbSel      = ws;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0);
    tick();
    tick();
    rstN = 1'b1;
    #1;
  endtask

  // Reference decode from the RV32I field rules.
  // Immediates are rebuilt with integer weights and two's-complement
  // wrap-around rather than bit concatenation.
  function automatic decT refDecode(input logic [31:0] w);
    decT d;
    logic [6:0] op;
    bit sup, u1, u2;
    int v;
    op  = w[6:0];
    sup = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    u1  = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    u2  = op inside {7'h33, 7'h23, 7'h63};
    d.rs1 = u1 ? w[19:15] : 5'd0;
    d.rs2 = u2 ? w[24:20] : 5'd0;
    d.rd  = w[11:7];
    d.wd  = sup && !(op inside {7'h23, 7'h63}) && (w[11:7] != 5'd0);
    d.ill = !sup;
    v = 0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        v = int'(w[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17: v = int'(w & 32'hFFFFF000);
      7'h6F: begin
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      default: v = 0;
    endcase
    d.imm = 32'(v);
    return d;
  endfunction

  function automatic bit pendingVisible(input logic [4:0] r);
    return (r != 5'd0) && mPend[r] && !(wbEn && (wbSel == r));
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    logic [6:0] ops [10];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
    k = $urandom_range(0, 9);
    w = $urandom;
    w[6:0]   = (k == 9) ? 7'($urandom) : ops[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    logic [31:0] word;

    vecs[0]  = '{32'h02B00193, 5'd0, 5'd0, 5'd3,  32'd43,        1'b1, 1'b0};
    vecs[1]  = '{32'h00318233, 5'd3, 5'd3, 5'd4,  32'd0,         1'b1, 1'b0};
    vecs[2]  = '{32'h00302423, 5'd0, 5'd3, 5'd8,  32'd8,         1'b0, 1'b0};
    vecs[3]  = '{32'h00100013, 5'd0, 5'd0, 5'd0,  32'd1,         1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 5'd0, 5'd0, 5'd31, 32'd0,         1'b0, 1'b1};
    vecs[5]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5,  32'h12345000,  1'b1, 1'b0};
    vecs[6]  = '{32'hFE208CE3, 5'd1, 5'd2, 5'd25, 32'hFFFFFFF8,  1'b0, 1'b0};
    vecs[7]  = '{32'h001000EF, 5'd0, 5'd0, 5'd1,  32'h00000800,  1'b1, 1'b0};
    vecs[8]  = '{32'hFFC08067, 5'd1, 5'd0, 5'd0,  32'hFFFFFFFC,  1'b0, 1'b0};
    vecs[9]  = '{32'hFFF12303, 5'd2, 5'd0, 5'd6,  32'hFFFFFFFF,  1'b1, 1'b0};
    vecs[10] = '{32'hFFFFF397, 5'd0, 5'd0, 5'd7,  32'hFFFFF000,  1'b1, 1'b0};
    vecs[11] = '{32'h8054A023, 5'd9, 5'd5, 5'd0,  32'hFFFFF800,  1'b0, 1'b0};

    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0);

    // Reset state, then release with nothing offered.
    tick();
    tick();
    checkOutput("rst_valid", decValid, 1'b0);
    checkOutput("rst_rden", rdEn, 1'b0);
    checkOutput("rst_illegal", illegal, 1'b0);
    checkOutput("rst_wden", decWdEn, 1'b0);
    checkOutput("rst_imm", decImm, 32'h0);
    checkOutput("rst_pc", decPc, 32'h0);
    rstN = 1'b1;
    #1;
    checkOutput("rst_ready", instrReady, 1'b1);
    tick();
    checkOutput("idle_valid", decValid, 1'b0);

    // addi x3,x0,43 accepted with one-cycle latency.
    applyStimulus(1'b1, 32'h02B00193, 32'h100, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("addi_ready", instrReady, 1'b1);
    tick();
    checkOutput("addi_valid", decValid, 1'b1);
    checkOutput("addi_rden", rdEn, 1'b1);
    checkOutput("addi_rd", decRd, 5'd3);
    checkOutput("addi_imm", decImm, 32'd43);
    checkOutput("addi_wden", decWdEn, 1'b1);
    checkOutput("addi_rs1", rs1Add, 5'd0);
    checkOutput("addi_rs2", rs2Add, 5'd0);
    checkOutput("addi_pc", decPc, 32'h100);

    // add x4,x3,x3 stalls on x3 until writeback of x3 is seen.
    applyStimulus(1'b1, 32'h00318233, 32'h104, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("raw_stall", instrReady, 1'b0);
    tick();
    checkOutput("raw_drain_valid", decValid, 1'b0);
    checkOutput("raw_drain_rden", rdEn, 1'b0);
    checkOutput("raw_still_stall", instrReady, 1'b0);
    wbEn  = 1'b1;
    wbSel = 5'd3;
    #1;
    checkOutput("raw_wb_through", instrReady, 1'b1);
    tick();
    wbEn = 1'b0;
    checkOutput("raw_valid", decValid, 1'b1);
    checkOutput("raw_rs1", rs1Add, 5'd3);
    checkOutput("raw_rs2", rs2Add, 5'd3);
    checkOutput("raw_rd", decRd, 5'd4);

    // sw x3,8(x0) held under back-pressure.
    applyStimulus(1'b1, 32'h00302423, 32'h108, 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 32'h00500293, 32'h10C, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("hold_ready", instrReady, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_valid", decValid, 1'b1);
      checkOutput("hold_imm", decImm, 32'd8);
      checkOutput("hold_rs2", rs2Add, 5'd3);
      checkOutput("hold_wden", decWdEn, 1'b0);
      checkOutput("hold_pc", decPc, 32'h108);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("release_ready", instrReady, 1'b1);
    tick();
    checkOutput("release_drain", decValid, 1'b0);
    instr = 32'h008404B3;
    #1;
    checkOutput("sw_no_pend_x8", instrReady, 1'b1);
    instr = 32'h000202B3;
    #1;
    checkOutput("pend_x4_kept", instrReady, 1'b0);

    // Writes to x0 never pend; reads of x0 never stall.
    applyStimulus(1'b1, 32'h00100013, 32'h110, 1'b1, 1'b0, 5'd0);
    tick();
    checkOutput("x0_wden", decWdEn, 1'b0);
    applyStimulus(1'b1, 32'h000002B3, 32'h114, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("x0_read_ready", instrReady, 1'b1);
    tick();
    checkOutput("x0_read_valid", decValid, 1'b1);
    checkOutput("x0_read_pc", decPc, 32'h114);

    // Illegal opcode whose rs1 field names pending x4 still flows.
    applyStimulus(1'b1, 32'h0002007F, 32'h118, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("ill_ready", instrReady, 1'b1);
    tick();
    checkOutput("ill_flag", illegal, 1'b1);
    checkOutput("ill_wden", decWdEn, 1'b0);
    checkOutput("ill_rs1", rs1Add, 5'd0);
    checkOutput("ill_imm", decImm, 32'h0);

    // Reset asserted in the middle of a RAW stall.
    resetDut();
    applyStimulus(1'b1, 32'h02B00193, 32'h200, 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 32'h00318233, 32'h204, 1'b1, 1'b0, 5'd0);
    #1;
    checkOutput("mid_stall", instrReady, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_valid", decValid, 1'b0);
    checkOutput("mid_rst_rden", rdEn, 1'b0);
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("post_rst_ready", instrReady, 1'b1);
    tick();
    checkOutput("post_rst_valid", decValid, 1'b1);
    checkOutput("post_rst_rd", decRd, 5'd4);
    checkOutput("post_rst_rs1", rs1Add, 5'd3);

    // Decode table, each entry presented from a clean scoreboard.
    for (int i = 0; i < 12; i++) begin
      resetDut();
      word = vecs[i].word;
      applyStimulus(1'b1, word, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 5'd0);
      tick();
      instrValid = 1'b0;
      checkOutput("tbl_valid", decValid, 1'b1);
      checkOutput("tbl_opcode", decOpcode, word[6:0]);
      checkOutput("tbl_funct3", decFunct3, word[14:12]);
      checkOutput("tbl_funct7", decFunct7, word[31:25]);
      checkOutput("tbl_rd", decRd, vecs[i].rd);
      checkOutput("tbl_rs1", rs1Add, vecs[i].rs1);
      checkOutput("tbl_rs2", rs2Add, vecs[i].rs2);
      checkOutput("tbl_imm", decImm, vecs[i].imm);
      checkOutput("tbl_wden", decWdEn, vecs[i].wdEn);
      checkOutput("tbl_illegal", illegal, vecs[i].ill);
      checkOutput("tbl_pc", decPc, 32'h1000 + 32'(i * 4));
    end

    // Randomized traffic against the behavioural model.
    resetDut();
    for (int r = 0; r < 32; r++) mPend[r] = 1'b0;
    mValid = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] w;
      decT d;
      bit hz, rdy, acc;
      w = randInstr();
      applyStimulus($urandom_range(0, 3) != 0, w, $urandom,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)));
      #1;
      d   = refDecode(w);
      hz  = pendingVisible(d.rs1) || pendingVisible(d.rs2);
      rdy = (!mValid || decReady) && !hz;
      checkOutput("rand_ready", instrReady, rdy);
      acc = instrValid && rdy;
      if (wbEn && (wbSel != 5'd0)) mPend[wbSel] = 1'b0;
      if (acc && d.wd) mPend[d.rd] = 1'b1;
      if (acc) begin
        mValid = 1'b1;
        mDec   = d;
        mWord  = w;
        mPc    = pcIn;
      end else if (decReady) begin
        mValid = 1'b0;
      end
      tick();
      checkOutput("rand_valid", decValid, mValid);
      checkOutput("rand_rden", rdEn, mValid);
      if (mValid) begin
        checkOutput("rand_opcode", decOpcode, mWord[6:0]);
        checkOutput("rand_funct3", decFunct3, mWord[14:12]);
        checkOutput("rand_funct7", decFunct7, mWord[31:25]);
        checkOutput("rand_rd", decRd, mDec.rd);
        checkOutput("rand_rs1", rs1Add, mDec.rs1);
        checkOutput("rand_rs2", rs2Add, mDec.rs2);
        checkOutput("rand_imm", decImm, mDec.imm);
        checkOutput("rand_wden", decWdEn, mDec.wd);
        checkOutput("rand_illegal", illegal, mDec.ill);
        checkOutput("rand_pc", decPc, mPc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction decode stage sitting directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake.
- Drives register-file read addresses and read enable.
- Registers decoded fields for the execute stage.
- Keeps a 32-entry pending-write scoreboard that stalls read-after-write hazards until writeback clears them.

Parameters:
XLEN, 32, datapath / instruction / PC width
REG_ADDR_W, 5, register address width (32 architectural registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
instr_valid  in  1  upstream instruction valid
instr_ready  out  1  stage can accept instruction this cycle
instr  in  XLEN  instruction word
pc_in  in  XLEN  instruction PC
rs1_add  out  REG_ADDR_W  register-file read address 1
rs2_add  out  REG_ADDR_W  register-file read address 2
rd_en  out  1  register-file read enable
dec_valid  out  1  decoded instruction valid
dec_ready  in  1  execute stage accepts decoded instruction
dec_opcode  out  7  instr[6:0]
dec_funct3  out  3  instr[14:12]
dec_funct7  out  7  instr[31:25]
dec_rd  out  REG_ADDR_W  destination register
dec_wd_en  out  1  instruction writes rd
dec_imm  out  XLEN  sign-extended immediate
dec_pc  out  XLEN  registered pc_in
illegal  out  1  unsupported opcode
wb_en  in  1  writeback of a register this cycle
wb_sel  in  REG_ADDR_W  register being written back

Behaviour:
- Reset (rst=0, async): dec_valid=0, rd_en=0, illegal=0, dec_wd_en=0. All other outputs 0. Scoreboard all-clear. instr_ready then follows its normal rule.
- Supported opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Any other opcode sets illegal=1 and dec_wd_en=0, uses no source registers, and sets no scoreboard bit. It still flows through the stage.
- Source use:
  - use_rs1 = R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - use_rs2 = R, STORE, BRANCH.
- Write-enable and immediates:
  - dec_wd_en = 1 for all supported opcodes except STORE and BRANCH, and only when rd != 0.
  - Immediates use the standard I/S/B/U/J formats, sign-extended to XLEN. R and illegal instructions give imm = 0.
- Hazard, evaluated combinationally on the incoming instr:
  - A hazard exists when (use_rs1 and pending[rs1]) or (use_rs2 and pending[rs2]).
  - A pending bit being cleared by wb_en/wb_sel in the same cycle does not count as a hazard (register-file write-through).
- Handshake and accept:
  - instr_ready = (!dec_valid || dec_ready) && !hazard.
  - accept = instr_valid && instr_ready.
  - On accept, all dec_* outputs, rs1_add, rs2_add and illegal load on the next edge, with dec_valid=1 and rd_en=1. Latency is 1 cycle, and register-file read addresses align with dec_valid.
  - If rs1 or rs2 is unused, its address is forced to 0.
- Output hold and drain:
  - If dec_valid && !dec_ready, all outputs hold stable.
  - If dec_ready && !accept, dec_valid and rd_en go to 0 next cycle.
- Scoreboard:
  - The bit for dec_rd is set on accept of an instruction with dec_wd_en=1.
  - The bit for wb_sel is cleared when wb_en=1.
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is permanently 0. wb_en with wb_sel=0 is ignored.
- Reset mid-stall clears the scoreboard and output register immediately. No instruction is retained.
- Full throughput (one instruction per cycle) with dec_ready=1 and no hazards.

Test Plan:
1. Reset with rst=0 for 2 cycles, then release with instr_valid=0 -> dec_valid=0, rd_en=0, instr_ready=1, scoreboard clear.
2. addi x3,x0,43 (0x02B00193) with dec_ready=1 -> next cycle dec_valid=1, dec_rd=3, dec_imm=43, dec_wd_en=1, rs1_add=0, rs2_add=0, pending[3]=1.
3. add x4,x3,x3 (0x00318233) presented right after step 2 with no writeback -> instr_ready=0 held. Assert wb_en=1, wb_sel=3 -> instr_ready=1 that same cycle. Next cycle rs1_add=3, rs2_add=3, dec_rd=4.
4. dec_ready=0 while holding sw x3,8(x0) (0x00302423) -> outputs stable, instr_ready=0. Release -> dec_wd_en=0, dec_imm=8, rs2_add=3, no scoreboard bit set.
5. addi x0,x0,1 (0x00100013), then an instruction reading x0 -> no stall, dec_wd_en=0. Opcode 0x7F -> illegal=1, dec_wd_en=0.
6. Assert rst=0 during the stall of step 3 -> dec_valid=0 immediately, pending cleared. After release, add x4,x3,x3 is accepted without stall.
